// File: rtl/mio_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mio_bus_bridge_pkg
//  Purpose  : Shared width codes, region decode constant and access helpers
//             for the memory/IO bus bridge.
//  Revision : 1.0  initial release
// ============================================================================
package mio_bus_bridge_pkg;

    // Core data-memory width codes (dm_ctrl)
    localparam logic [2:0] DM_WORD          = 3'b000;
    localparam logic [2:0] DM_HALFWORD      = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNS  = 3'b010;
    localparam logic [2:0] DM_BYTE          = 3'b011;
    localparam logic [2:0] DM_BYTE_UNS      = 3'b100;

    // addr[31:28] value that selects the peripheral bus
    localparam logic [3:0] IO_REGION = 4'hF;

    typedef enum logic [1:0] {
        ACC_WORD = 2'd0,
        ACC_HALF = 2'd1,
        ACC_BYTE = 2'd2
    } acc_size_e;

    // Undefined width codes fall back to a full word access.
    function automatic acc_size_e dm_size(input logic [2:0] dm);
        acc_size_e size;
        case (dm)
            DM_HALFWORD, DM_HALFWORD_UNS: size = ACC_HALF;
            DM_BYTE, DM_BYTE_UNS:         size = ACC_BYTE;
            default:                      size = ACC_WORD;
        endcase
        return size;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] dm, input logic [1:0] addr_lo);
        logic bad;
        case (dm_size(dm))
            ACC_WORD: bad = (addr_lo != 2'b00);
            ACC_HALF: bad = addr_lo[0];
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic is_signed_load(input logic [2:0] dm);
        return (dm == DM_BYTE) || (dm == DM_HALFWORD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mio_bus_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : mio_bus_bridge_if
//  Purpose  : CPU-side, RAM-side and peripheral-side signals of the bridge.
//             slave  = the bridge itself, master = its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface mio_bus_bridge_if #(
    parameter int RAM_AW = 10
);
    // CPU data-access port
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [2:0]         cpu_dm_ctrl;
    logic [31:0]        cpu_rdata;
    logic               cpu_ready;
    logic               cpu_err;
    // Data RAM port
    logic               ram_en;
    logic [3:0]         ram_we;
    logic [RAM_AW-1:0]  ram_addr;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;
    // Peripheral bus port
    logic               io_req;
    logic               io_we;
    logic [31:0]        io_addr;
    logic [31:0]        io_wdata;
    logic [3:0]         io_be;
    logic [31:0]        io_rdata;
    logic               io_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dm_ctrl,
        output cpu_rdata, cpu_ready, cpu_err,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output io_req, io_we, io_addr, io_wdata, io_be,
        input  io_rdata, io_ack
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dm_ctrl,
        input  cpu_rdata, cpu_ready, cpu_err,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  io_req, io_we, io_addr, io_wdata, io_be,
        output io_rdata, io_ack
    );
endinterface
`default_nettype wire

// File: rtl/mio_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mio_lane_align
//  Purpose  : Byte-lane mask, store-data replication and load-data lane
//             extraction with sign/zero extension. Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module mio_lane_align
    import mio_bus_bridge_pkg::*;
(
    input  wire logic [1:0]  addr_lo,
    input  wire logic [2:0]  dm_ctrl,
    input  wire logic [31:0] wdata,
    input  wire logic [31:0] rdata_raw,
    output logic      [3:0]  lane_mask,
    output logic      [31:0] wdata_rep,
    output logic      [31:0] rdata_ext
);

    logic [31:0] w_shifted;
    logic        w_signed;

    // Lane selection and extension depend only on the access size and offset.
    always_comb begin
        lane_mask = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
        w_shifted = rdata_raw;
        w_signed  = is_signed_load(dm_ctrl);
        case (dm_size(dm_ctrl))
            ACC_BYTE: begin
                lane_mask = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                w_shifted = rdata_raw >> {addr_lo, 3'b000};
                rdata_ext = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            ACC_HALF: begin
                lane_mask = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                w_shifted = rdata_raw >> {addr_lo[1], 4'b0000};
                rdata_ext = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                lane_mask = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata_raw;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mio_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mio_bus_bridge
//  Purpose  : Routes core data accesses to the word-addressed RAM (1-cycle
//             read latency) or the ack-based peripheral bus, returning
//             extended load data with a one-cycle ready pulse.
//  Revision : 1.0  initial release
// ============================================================================
module mio_bus_bridge
    import mio_bus_bridge_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int IO_TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mio_bus_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RAM_ACC = 2'd1,
        S_IO_ACC  = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    // Counter value seen in the last permitted IO_ACC cycle.
    localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

    state_e      r_state;
    state_e      w_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_dm;
    logic        r_err;
    logic        r_is_io;
    logic [31:0] r_io_rdata;
    logic [7:0]  r_cnt;

    logic        w_req_misaligned;
    logic        w_req_is_io;
    logic        w_io_expired;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;

    assign w_req_misaligned = is_misaligned(bus.cpu_dm_ctrl, bus.cpu_addr[1:0]);
    assign w_req_is_io      = (bus.cpu_addr[31:28] == IO_REGION);
    assign w_io_expired     = (r_cnt == TO_LAST);

    // RAM data arrives during RESP; IO data was captured with the ack.
    mio_lane_align u_lane_align (
        .addr_lo   (r_addr[1:0]),
        .dm_ctrl   (r_dm),
        .wdata     (r_wdata),
        .rdata_raw (r_is_io ? r_io_rdata : bus.ram_rdata),
        .lane_mask (w_lane_mask),
        .wdata_rep (w_wdata_rep),
        .rdata_ext (w_rdata_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Request latch, timeout counter and peripheral read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dm       <= '0;
            r_err      <= 1'b0;
            r_is_io    <= 1'b0;
            r_io_rdata <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.cpu_req) begin
                        r_we       <= bus.cpu_we;
                        r_addr     <= bus.cpu_addr;
                        r_wdata    <= bus.cpu_wdata;
                        r_dm       <= bus.cpu_dm_ctrl;
                        r_err      <= w_req_misaligned;
                        r_is_io    <= w_req_is_io;
                        r_io_rdata <= '0;
                    end
                end
                S_IO_ACC: begin
                    r_cnt <= r_cnt + 8'd1;
                    // An ack in the expiry cycle still completes cleanly.
                    if (bus.io_ack)        r_io_rdata <= bus.io_rdata;
                    else if (w_io_expired) r_err      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next        = r_state;
        bus.cpu_rdata = '0;
        bus.cpu_ready = 1'b0;
        bus.cpu_err   = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.io_req    = 1'b0;
        bus.io_we     = 1'b0;
        bus.io_addr   = '0;
        bus.io_wdata  = '0;
        bus.io_be     = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    if (w_req_misaligned) w_next = S_RESP;
                    else if (w_req_is_io) w_next = S_IO_ACC;
                    else                  w_next = S_RAM_ACC;
                end
            end
            S_RAM_ACC: begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = r_we ? w_lane_mask : 4'b0000;
                bus.ram_addr  = r_addr[RAM_AW+1:2];
                bus.ram_wdata = w_wdata_rep;
                w_next        = S_RESP;
            end
            S_IO_ACC: begin
                bus.io_req   = 1'b1;
                bus.io_we    = r_we;
                bus.io_addr  = r_addr;
                bus.io_wdata = w_wdata_rep;
                bus.io_be    = w_lane_mask;
                if (bus.io_ack || w_io_expired) w_next = S_RESP;
            end
            S_RESP: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_err   = r_err;
                bus.cpu_rdata = (r_err || r_we) ? 32'h0 : w_rdata_ext;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
